cbus_ram_responder: RTL

- Synthesizable cache-bus (cbus) responder: the memory end of the cbus_req_t/cbus_resp_t protocol that the core's bus converters and arbiter drive.
- Backed by an on-chip word array with configurable access latency.
- Supports single and burst transfers with byte strobes.
- Used as the memory model in core-level sims and as a local scratch RAM behind the arbiter.

---
 rtl/cbus_pkg.sv | 21 ++
 rtl/cbus_ram_responder_pkg.sv | 24 ++
 rtl/cbus_burst_idx_gen.sv | 37 +++
 rtl/cbus_ram_responder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cbus_pkg.sv
// Common cache-bus request/response types shared by converters, arbiter and responders.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_ram_responder_pkg.sv
// Burst encodings, responder state constants and stall-LFSR taps for cbus_ram_responder.
package cbus_ram_responder_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_BEAT = 2'd2;

    // Fibonacci taps 8,6,5,4 on a left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic wrap_len_ok(input logic [3:0] len);
        logic ok;
        case (len)
            4'd1, 4'd3, 4'd7, 4'd15: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cbus_burst_idx_gen.sv
// Next word index for FIXED/INCR/WRAP bursts; WRAP with an unsupported length behaves as INCR.
module cbus_burst_idx_gen
    import cbus_ram_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic [ADDR_BITS-1:0] i_cur_idx,
    input  logic [ADDR_BITS-1:0] i_start_idx,
    input  logic [3:0]           i_len,
    input  logic [1:0]           i_burst,
    output logic [ADDR_BITS-1:0] o_next_idx
);

    logic [ADDR_BITS-1:0] w_incr;
    logic [ADDR_BITS-1:0] w_mask;

    assign w_incr = i_cur_idx + ADDR_BITS'(1);
    assign w_mask = ADDR_BITS'(i_len);

    // Select the next index according to the burst type
    always_comb begin
        o_next_idx = w_incr;
        case (i_burst)
            BURST_FIXED: o_next_idx = i_cur_idx;
            BURST_INCR:  o_next_idx = w_incr;
            BURST_WRAP: begin
                if (wrap_len_ok(i_len)) begin
                    o_next_idx = (i_start_idx & ~w_mask) | (w_incr & w_mask);
                end else begin
                    o_next_idx = w_incr;
                end
            end
            default:     o_next_idx = w_incr;
        endcase
    end

endmodule

// File: rtl/cbus_ram_responder.sv
// cbus memory responder backed by a word array with configurable latency.
// Optional random ready stalls when CBUS_RESP_STALL_EN is defined.
module cbus_ram_responder
    import cbus_pkg::*;
    import cbus_ram_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned LATENCY   = 2,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    logic [1:0]           r_state;
    logic [3:0]           r_wait_cnt;
    logic [3:0]           r_beat;
    logic [3:0]           r_len;
    logic [1:0]           r_burst;
    logic                 r_is_write;
    logic [ADDR_BITS-1:0] r_idx;
    logic [ADDR_BITS-1:0] r_start_idx;
    logic [31:0]          r_mem [0:(1<<ADDR_BITS)-1];

    logic                 w_stall;
    logic                 w_beat;
    logic                 w_last;
    logic [ADDR_BITS-1:0] w_next_idx;
    logic                 w_unused_bits;

    assign w_unused_bits = ^{creq.size, creq.addr[31:ADDR_BITS+2], creq.addr[1:0]};

`ifdef CBUS_RESP_STALL_EN
    logic [7:0] r_lfsr;
    logic [1:0] r_stall_cnt;

    assign w_stall = (r_state == ST_BEAT) && r_lfsr[0] && (r_stall_cnt != 2'd3);

    // Free-running stall LFSR and consecutive-stall counter that forces a beat after three stalls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lfsr      <= LFSR_SEED;
            r_stall_cnt <= 2'd0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
            if ((r_state == ST_BEAT) && creq.valid && w_stall) begin
                r_stall_cnt <= r_stall_cnt + 2'd1;
            end else begin
                r_stall_cnt <= 2'd0;
            end
        end
    end
`else
    logic w_unused_seed;
    assign w_unused_seed = ^LFSR_SEED;
    assign w_stall       = 1'b0;
`endif

    assign w_beat = (r_state == ST_BEAT) && creq.valid && !w_stall;
    assign w_last = w_beat && (r_beat == r_len);

    cbus_burst_idx_gen #(.ADDR_BITS(ADDR_BITS)) u_idx_gen (
        .i_cur_idx   (r_idx),
        .i_start_idx (r_start_idx),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_idx  (w_next_idx)
    );

    // Response: read data only on a read beat, everything low otherwise
    always_comb begin
        cresp.ready = w_beat;
        cresp.last  = w_last;
        if (w_beat && !r_is_write) begin
            cresp.data = r_mem[r_idx];
        end else begin
            cresp.data = 32'd0;
        end
    end

    // Request acceptance, latency countdown and beat sequencing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 4'd0;
            r_beat      <= 4'd0;
            r_len       <= 4'd0;
            r_burst     <= BURST_FIXED;
            r_is_write  <= 1'b0;
            r_idx       <= '0;
            r_start_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (creq.valid) begin
                        r_idx       <= creq.addr[ADDR_BITS+1:2];
                        r_start_idx <= creq.addr[ADDR_BITS+1:2];
                        r_len       <= creq.len;
                        r_burst     <= creq.burst;
                        r_is_write  <= creq.is_write;
                        r_beat      <= 4'd0;
                        r_wait_cnt  <= 4'(LATENCY);
                        r_state     <= (LATENCY == 0) ? ST_BEAT : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!creq.valid) begin
                        r_state <= ST_IDLE;
                    end else if (r_wait_cnt <= 4'd1) begin
                        r_wait_cnt <= 4'd0;
                        r_state    <= ST_BEAT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                ST_BEAT: begin
                    if (!creq.valid) begin
                        r_state <= ST_IDLE;
                    end else if (w_last) begin
                        r_state <= ST_IDLE;
                    end else if (w_beat) begin
                        r_idx  <= w_next_idx;
                        r_beat <= r_beat + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Byte-lane writes into the array; contents survive reset
    always_ff @(posedge clk) begin
        if (w_beat && r_is_write) begin
            for (int i = 0; i < 4; i++) begin
                if (creq.strobe[i]) begin
                    r_mem[r_idx][8*i +: 8] <= creq.data[8*i +: 8];
                end
            end
        end
    end

endmodule
